// File: rtl/bus2to1_arbiter.sv
// Round-robin arbiter merging two valid/ready masters onto one slave bus with a response watchdog.
// Latency: request to s_valid 1 cycle; s_ready to mx_ready 0 cycles; at least one idle cycle between grants.
// Backpressure: the grant is held while s_ready is low, until completion or watchdog abort.
module bus2to1_arbiter #(
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    output logic [31:0] m1_rdata,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,

    input  logic        m2_valid,
    output logic        m2_ready,
    input  logic [31:0] m2_addr,
    output logic [31:0] m2_rdata,
    input  logic [31:0] m2_wdata,
    input  logic [3:0]  m2_wstrb,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    input  logic [31:0] s_rdata,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,

    output logic        timeout
);

    // A zero TIMEOUT keeps a 1-bit counter that is never compared.
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } state_t;

    localparam logic LAST_M1 = 1'b0;
    localparam logic LAST_M2 = 1'b1;

    state_t          state;
    state_t          state_nxt;
    logic            last_gnt;
    logic            last_gnt_nxt;
    logic [CW-1:0]   wd_cnt;
    logic [CW-1:0]   wd_cnt_nxt;
    logic            gnt_valid;
    logic            abort;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            last_gnt <= LAST_M2;
            wd_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            wd_cnt   <= wd_cnt_nxt;
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        case (state)
            GNT1:    gnt_valid = m1_valid;
            GNT2:    gnt_valid = m2_valid;
            default: gnt_valid = 1'b0;
        endcase
    end

    // A slave response arriving in the abort cycle takes precedence over the abort.
    assign abort = (TIMEOUT > 0) && gnt_valid && !s_ready && (wd_cnt == WD_LAST);

    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        wd_cnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (m1_valid && (!m2_valid || last_gnt == LAST_M2)) begin
                    state_nxt    = GNT1;
                    last_gnt_nxt = LAST_M1;
                end else if (m2_valid) begin
                    state_nxt    = GNT2;
                    last_gnt_nxt = LAST_M2;
                end
            end
            GNT1, GNT2: begin
                if (!gnt_valid || s_ready || abort) begin
                    state_nxt = IDLE;
                end else begin
                    wd_cnt_nxt = wd_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        m2_ready = 1'b0;
        m2_rdata = '0;
        timeout  = 1'b0;
        case (state)
            GNT1: begin
                s_valid  = m1_valid && !abort;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = abort || s_ready;
                m1_rdata = abort ? ERR_RDATA : s_rdata;
                timeout  = abort;
            end
            GNT2: begin
                s_valid  = m2_valid && !abort;
                s_addr   = m2_addr;
                s_wdata  = m2_wdata;
                s_wstrb  = m2_wstrb;
                m2_ready = abort || s_ready;
                m2_rdata = abort ? ERR_RDATA : s_rdata;
                timeout  = abort;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus2to1_arbiter.sv
// Directed bench for bus2to1_arbiter: expected completions go to a queue, a negedge monitor checks every ready pulse.
module tb_bus2to1_arbiter;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m1_valid, m1_ready, m2_valid, m2_ready;
    logic [31:0] m1_addr, m1_rdata, m1_wdata, m2_addr, m2_rdata, m2_wdata;
    logic [3:0]  m1_wstrb, m2_wstrb, s_wstrb;
    logic        s_valid, s_ready, timeout;
    logic [31:0] s_addr, s_rdata, s_wdata;

    typedef struct {
        int          m;
        logic [31:0] rd;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    bus2to1_arbiter #(.TIMEOUT(8), .ERR_RDATA(ERR)) dut (
        .clk(clk), .resetn(resetn),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_rdata(m1_rdata),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m2_valid(m2_valid), .m2_ready(m2_ready), .m2_addr(m2_addr), .m2_rdata(m2_rdata),
        .m2_wdata(m2_wdata), .m2_wstrb(m2_wstrb),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_rdata(s_rdata),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push(input int m, input logic [31:0] rd, input logic to);
        exp_t e;
        e.m  = m;
        e.rd = rd;
        e.to = to;
        sb.push_back(e);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_s_valid"},  32'(s_valid),  0);
        chk({nm, "_m1_ready"}, 32'(m1_ready), 0);
        chk({nm, "_m2_ready"}, 32'(m2_ready), 0);
        chk({nm, "_timeout"},  32'(timeout),  0);
        chk({nm, "_m1_rdata"}, m1_rdata, 0);
        chk({nm, "_m2_rdata"}, m2_rdata, 0);
        chk({nm, "_s_addr"},   s_addr, 0);
    endtask

    // Monitor: every ready pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (m1_ready === 1'b1 || m2_ready === 1'b1) begin
            chk("sb_both_ready", 32'(m1_ready & m2_ready), 0);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected_ready: m1_ready=%b m2_ready=%b, expected no completion", m1_ready, m2_ready);
            end else begin
                exp_t e;
                int   am;
                e  = sb.pop_front();
                am = m1_ready ? 1 : 2;
                chk("sb_master",  32'(am), 32'(e.m));
                chk("sb_rdata",   (am == 1) ? m1_rdata : m2_rdata, e.rd);
                chk("sb_timeout", 32'(timeout), 32'(e.to));
            end
        end
    end

    initial begin
        resetn = 1'b0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        m2_valid = 1'b0; m2_addr = '0; m2_wdata = '0; m2_wstrb = '0;
        s_ready = 1'b0; s_rdata = '0;
        next_cycle();
        next_cycle();
        mid();
        chk_idle("reset");

        // 1: single m1 read, slave answers on the third cycle
        next_cycle(); resetn = 1'b1; m1_valid = 1'b1; m1_addr = 32'h0000_0100;
        mid(); chk("t1_svalid_req_cycle", 32'(s_valid), 0);
        next_cycle();
        mid(); chk("t1_svalid_gnt", 32'(s_valid), 1); chk("t1_saddr", s_addr, 32'h0000_0100);
        chk("t1_m1_ready_stall", 32'(m1_ready), 0);
        next_cycle(); s_ready = 1'b1; s_rdata = 32'h1234_5678; push(1, 32'h1234_5678, 1'b0);
        mid(); chk("t1_m2_ready", 32'(m2_ready), 0);
        next_cycle(); m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
        mid(); chk("t1_svalid_after", 32'(s_valid), 0);

        // 2: both masters requesting from reset, slave always ready
        next_cycle(); resetn = 1'b0;
        next_cycle(); resetn = 1'b1;
        m1_valid = 1'b1; m1_addr = 32'h0000_1000; m2_valid = 1'b1; m2_addr = 32'h0000_2000;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) next_cycle();
            s_ready = 1'b1;
            s_rdata = 32'h5A00_0000 | 32'(k);
            if (k % 2 == 1) push((k % 4 == 1) ? 1 : 2, 32'h5A00_0000 | 32'(k), 1'b0);
            mid();
            chk("t2_svalid", 32'(s_valid), 32'(k % 2));
            if (k % 2 == 1)
                chk("t2_saddr", s_addr, (k % 4 == 1) ? 32'h0000_1000 : 32'h0000_2000);
        end
        next_cycle(); m1_valid = 1'b0; m2_valid = 1'b0; s_ready = 1'b0;
        mid(); chk("t2_svalid_end", 32'(s_valid), 0);

        // 3: m2 write forwarded verbatim, m1 sees nothing
        next_cycle(); m2_valid = 1'b1; m2_addr = 32'h0000_0200; m2_wdata = 32'hCAFE_F00D;
        m2_wstrb = 4'b0011; s_rdata = 32'h1111_1111;
        mid(); chk("t3_m1_rdata_idle", m1_rdata, 0);
        next_cycle();
        mid();
        chk("t3_svalid", 32'(s_valid), 1);
        chk("t3_saddr", s_addr, 32'h0000_0200);
        chk("t3_swdata", s_wdata, 32'hCAFE_F00D);
        chk("t3_swstrb", 32'(s_wstrb), 32'h3);
        chk("t3_m1_rdata", m1_rdata, 0);
        chk("t3_m2_rdata", m2_rdata, 32'h1111_1111);
        next_cycle(); s_ready = 1'b1; push(2, 32'h1111_1111, 1'b0);
        mid(); chk("t3_m1_rdata_done", m1_rdata, 0);
        next_cycle(); m2_valid = 1'b0; m2_wstrb = '0; m2_wdata = '0; s_ready = 1'b0;
        mid();

        // 4: watchdog abort on m1 with m2 pending
        next_cycle(); m1_valid = 1'b1; m1_addr = 32'h0000_0300; m2_valid = 1'b1;
        m2_addr = 32'h0000_0400; s_rdata = 32'h7777_7777;
        mid(); chk("t4_svalid_req", 32'(s_valid), 0);
        for (int k = 1; k < 8; k++) begin
            next_cycle();
            mid();
            chk("t4_svalid_wait", 32'(s_valid), 1);
            chk("t4_timeout_wait", 32'(timeout), 0);
            chk("t4_saddr_wait", s_addr, 32'h0000_0300);
        end
        next_cycle(); push(1, ERR, 1'b1);
        mid(); chk("t4_svalid_abort", 32'(s_valid), 0); chk("t4_timeout_abort", 32'(timeout), 1);
        next_cycle(); m1_valid = 1'b0;
        mid(); chk("t4_bubble", 32'(s_valid), 0);
        next_cycle(); s_ready = 1'b1; s_rdata = 32'h2222_0000; push(2, 32'h2222_0000, 1'b0);
        mid(); chk("t4_m2_svalid", 32'(s_valid), 1); chk("t4_m2_saddr", s_addr, 32'h0000_0400);
        next_cycle(); m2_valid = 1'b0; s_ready = 1'b0;
        mid();

        // 5: slave response lands exactly on the abort cycle
        next_cycle(); m1_valid = 1'b1; m1_addr = 32'h0000_0500; s_rdata = 32'h3333_3333;
        mid();
        for (int k = 1; k < 8; k++) next_cycle();
        next_cycle(); s_ready = 1'b1; s_rdata = 32'h5555_AAAA; push(1, 32'h5555_AAAA, 1'b0);
        mid(); chk("t5_timeout", 32'(timeout), 0); chk("t5_svalid", 32'(s_valid), 1);
        next_cycle(); m1_valid = 1'b0; s_ready = 1'b0;
        mid();

        // 6: reset during a stalled m2 grant
        next_cycle(); m2_valid = 1'b1; m2_addr = 32'h0000_0600;
        mid();
        next_cycle();
        mid(); chk("t6_svalid_gnt2", 32'(s_valid), 1);
        next_cycle();
        next_cycle(); resetn = 1'b0;
        mid();
        next_cycle(); resetn = 1'b1; m1_valid = 1'b1; m1_addr = 32'h0000_0700;
        mid(); chk_idle("t6_after_reset");
        next_cycle(); s_ready = 1'b1; s_rdata = 32'h6666_0001; push(1, 32'h6666_0001, 1'b0);
        mid(); chk("t6_svalid_m1", 32'(s_valid), 1); chk("t6_saddr_m1", s_addr, 32'h0000_0700);
        next_cycle(); m1_valid = 1'b0; s_ready = 1'b0;
        mid(); chk("t6_bubble", 32'(s_valid), 0);
        next_cycle(); s_ready = 1'b1; s_rdata = 32'h6666_0002; push(2, 32'h6666_0002, 1'b0);
        mid(); chk("t6_saddr_m2", s_addr, 32'h0000_0600);
        next_cycle(); m2_valid = 1'b0; s_ready = 1'b0;
        next_cycle();
        mid();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
